seven_seg_scan_decoder: RTL and testbench
=========================================

SEVEN_SEG_SCAN_DECODER -- requirements
Module: seven_seg_scan_decoder

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, gives the consecutive identical samples required before a digit is captured (legal range 1-255).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000, gives the cycles without any capture before displayed data is declared stale (legal range 2 to 2^24-1).
REQ-003 Port clk, input, 1 bit: single clock; all inputs are synchronous to it.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port led_enb, input, 8 bits: active-low digit enables from the scan driver; bit i low selects digit i (i=0..3); bits 7:4 are always high in legal operation.
REQ-006 Port seg, input, 7 bits: active-low segments, seg[0]=a through seg[6]=g.
REQ-007 Port digit_value, output, 16 bits: captured hex nibbles, digit i in bits [4i+3:4i].
REQ-008 Port digit_valid, output, 4 bits: bit i high while digit i holds a successfully decoded glyph.
REQ-009 Port frame_valid, output, 1 bit: one-cycle pulse when all four digits have been captured since the last frame.
REQ-010 Port seg_error, output, 1 bit: one-cycle pulse when a capture holds a non-hex glyph.
REQ-011 Port enb_error, output, 1 bit: registered flag, high the cycle after an illegal led_enb sample.
REQ-012 Port stale, output, 1 bit: level, high after the timeout until the next capture.

Function
REQ-013 Each cycle, led_enb SHALL be classified: idle when all bits are high; legal when bits 7:4 are high and exactly one of bits 3:0 is low; illegal otherwise.
REQ-014 A dwell counter SHALL count consecutive legal samples with unchanged digit index and unchanged seg; a change in either, an idle sample, or an illegal sample restarts it.
REQ-015 Capture SHALL occur at the clock edge that completes SETTLE_CYCLES identical legal samples; results are visible on outputs on the following cycle.
REQ-016 Only one capture SHALL occur per dwell; further identical samples do not recapture until the index or seg changes.
REQ-017 Decode SHALL be active-low: ~seg is compared, as gfedcba, against 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
REQ-018 On a match, the nibble of digit i SHALL be written and digit_valid[i] set.
REQ-019 On no match, seg_error SHALL pulse, digit_valid[i] SHALL clear, and nibble i SHALL be unchanged.
REQ-020 Every capture, matched or not, SHALL set bit i of an internal seen mask; when the mask becomes 1111, frame_valid SHALL pulse in the same cycle the fourth capture becomes visible, and the mask SHALL clear.
REQ-021 Recapturing an already-seen digit before the frame completes SHALL update its value but SHALL NOT advance the frame.
REQ-022 An illegal sample SHALL set enb_error for exactly the next cycle, restart the dwell counter, and leave captured data untouched.
REQ-023 A timeout counter SHALL clear on every capture; on reaching TIMEOUT_CYCLES it SHALL set stale, clear digit_valid, and clear the seen mask; stale SHALL clear on the next capture.
REQ-024 When SETTLE_CYCLES=1, every legal sample that differs from the previous sample SHALL capture.

Reset
REQ-025 While reset is high at a clock edge, all of the following SHALL be zero on the next cycle: digit_value, digit_valid, frame_valid, seg_error, enb_error, stale, the dwell counter, the timeout counter, and the seen mask.
REQ-026 Reset SHALL take priority over capture, frame, and timeout events in the same cycle; after reset deasserts, a dwell SHALL start counting from zero.

Verification
REQ-027 With SETTLE_CYCLES=4, scan digits 0-3 with seg showing 1, 2, 3, 4 for 6 cycles each -> digit_value=16'h4321, digit_valid=4'hF, and frame_valid pulses once, 1 cycle after the 4th edge of digit 3's dwell.
REQ-028 Hold digit 2 for 3 cycles, then change seg -> no capture occurs and digit_valid[2] is unchanged.
REQ-029 Drive led_enb=8'hFC (two digits low) or 8'hEF -> enb_error is high for 1 cycle and no outputs change.
REQ-030 Drive seg=7'h7F (blank) on digit 1 for 4 cycles -> seg_error pulses, digit_valid[1]=0, and nibble 1 keeps its old value.
REQ-031 With TIMEOUT_CYCLES=100, make no captures for 100 cycles -> stale=1 and digit_valid=0; the next capture sets stale=0.
REQ-032 Assert reset in the middle of a dwell and in the middle of a frame -> all outputs are 0, and a full 4-cycle dwell is required afterwards before any capture.

Source files
------------

// File: rtl/seven_seg_scan_decoder.sv
// rtl/seven_seg_scan_decoder.sv - recovers hex digits from a multiplexed 4-digit seven-segment scan
//
// Watches the active-low digit enables and segment lines of a scanned display,
// waits for each digit's pattern to settle, decodes it back to a hex nibble and
// reports frame completion, undecodable glyphs, illegal enables and staleness.
//
// Ports:
//   clk          single clock, all inputs synchronous to it
//   reset        synchronous active-high reset
//   led_enb[7:0] active-low digit enables, bit i low selects digit i (0..3)
//   seg[6:0]     active-low segments, seg[0]=a .. seg[6]=g
//   digit_value  captured nibbles, digit i in [4i+3:4i]
//   digit_valid  bit i high while digit i holds a decoded glyph
//   frame_valid  one-cycle pulse when all four digits have been captured
//   seg_error    one-cycle pulse when a capture holds a non-hex glyph
//   enb_error    high the cycle after an illegal led_enb sample
//   stale        high after TIMEOUT_CYCLES without a capture, until the next one
module seven_seg_scan_decoder #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  led_enb,
    input  logic [6:0]  seg,
    output logic [15:0] digit_value,
    output logic [3:0]  digit_valid,
    output logic        frame_valid,
    output logic        seg_error,
    output logic        enb_error,
    output logic        stale
);

    localparam logic [7:0]  SETTLE_W  = 8'(SETTLE_CYCLES);
    localparam logic [23:0] TIMEOUT_W = 24'(TIMEOUT_CYCLES);

    logic [7:0]  dwell;
    logic [7:0]  dwell_next;
    logic        prev_legal;
    logic [1:0]  prev_idx;
    logic [6:0]  prev_seg;
    logic [23:0] tcnt;
    logic [3:0]  seen;
    logic [3:0]  seen_next;

    logic [3:0]  sel;
    logic        is_idle;
    logic        is_legal;
    logic        is_illegal;
    logic        onehot;
    logic [1:0]  idx;
    logic        same;
    logic        capture;
    logic        hit;
    logic [3:0]  nib;

    // Enable classification and digit index.
    always_comb begin
        sel    = ~led_enb[3:0];
        onehot = 1'b1;
        idx    = 2'd0;
        case (sel)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: onehot = 1'b0;
        endcase
        is_idle    = (led_enb == 8'hFF);
        is_legal   = (&led_enb[7:4]) && onehot;
        is_illegal = !is_idle && !is_legal;
    end

    // Dwell counting: saturates at SETTLE_W so a long dwell captures only once.
    // Capture fires on the edge the count first reaches SETTLE_W; when
    // SETTLE_CYCLES is 1 that is every fresh legal sample.
    always_comb begin
        same       = prev_legal && (idx == prev_idx) && (seg == prev_seg);
        dwell_next = 8'd0;
        if (is_legal) begin
            if (!same)
                dwell_next = 8'd1;
            else if (dwell == SETTLE_W)
                dwell_next = dwell;
            else
                dwell_next = dwell + 8'd1;
        end
        capture   = is_legal && (dwell_next == SETTLE_W) && (!same || (dwell != SETTLE_W));
        seen_next = seen | (4'b0001 << idx);
    end

    // Active-low decode: compare the inverted segments as gfedcba.
    always_comb begin
        hit = 1'b1;
        nib = 4'h0;
        case (~seg)
            7'h3F: nib = 4'h0;
            7'h06: nib = 4'h1;
            7'h5B: nib = 4'h2;
            7'h4F: nib = 4'h3;
            7'h66: nib = 4'h4;
            7'h6D: nib = 4'h5;
            7'h7D: nib = 4'h6;
            7'h07: nib = 4'h7;
            7'h7F: nib = 4'h8;
            7'h6F: nib = 4'h9;
            7'h77: nib = 4'hA;
            7'h7C: nib = 4'hB;
            7'h39: nib = 4'hC;
            7'h5E: nib = 4'hD;
            7'h79: nib = 4'hE;
            7'h71: nib = 4'hF;
            default: hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digit_value <= 16'h0;
            digit_valid <= 4'h0;
            frame_valid <= 1'b0;
            seg_error   <= 1'b0;
            enb_error   <= 1'b0;
            stale       <= 1'b0;
            dwell       <= 8'd0;
            prev_legal  <= 1'b0;
            prev_idx    <= 2'd0;
            prev_seg    <= 7'h0;
            tcnt        <= 24'd0;
            seen        <= 4'h0;
        end else begin
            enb_error   <= is_illegal;
            frame_valid <= 1'b0;
            seg_error   <= 1'b0;
            dwell       <= dwell_next;
            prev_legal  <= is_legal;
            prev_idx    <= idx;
            prev_seg    <= seg;
            if (capture) begin
                tcnt  <= 24'd0;
                stale <= 1'b0;
                if (hit) begin
                    digit_value[{idx, 2'b00} +: 4] <= nib;
                    digit_valid[idx]               <= 1'b1;
                end else begin
                    seg_error        <= 1'b1;
                    digit_valid[idx] <= 1'b0;
                end
                if (seen_next == 4'hF) begin
                    frame_valid <= 1'b1;
                    seen        <= 4'h0;
                end else begin
                    seen <= seen_next;
                end
            end else if (tcnt != TIMEOUT_W) begin
                // Counter parks at TIMEOUT_W so staleness is declared once.
                tcnt <= tcnt + 24'd1;
                if (tcnt + 24'd1 == TIMEOUT_W) begin
                    stale       <= 1'b1;
                    digit_valid <= 4'h0;
                    seen        <= 4'h0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// tb/tb_seven_seg_scan_decoder.sv - self-checking bench for seven_seg_scan_decoder
module tb_seven_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  led_enb;
    logic [6:0]  seg;
    logic [15:0] digit_value;
    logic [3:0]  digit_valid;
    logic        frame_valid;
    logic        seg_error;
    logic        enb_error;
    logic        stale;

    seven_seg_scan_decoder #(
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .led_enb     (led_enb),
        .seg         (seg),
        .digit_value (digit_value),
        .digit_valid (digit_valid),
        .frame_valid (frame_valid),
        .seg_error   (seg_error),
        .enb_error   (enb_error),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    // gfedcba glyphs for 0..F
    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int n_checks = 0;
    int n_fail   = 0;
    int frame_cnt  = 0;
    int segerr_cnt = 0;
    int segerr_base;
    logic [15:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] l, input logic [6:0] s, input int n);
        repeat (n) begin
            @(negedge clk);
            led_enb = l;
            seg     = s;
        end
    endtask

    task automatic hold_digit(input int d, input int g, input int n);
        drive(8'hFF ^ (8'h01 << d), ~glyph[g], n);
    endtask

    task automatic hold_raw(input int d, input logic [6:0] s, input int n);
        drive(8'hFF ^ (8'h01 << d), s, n);
    endtask

    task automatic idle(input int n);
        drive(8'hFF, 7'h7F, n);
    endtask

    // Scoreboard: every frame pulse must match the next queued expected value.
    always @(negedge clk) begin
        if (frame_valid) begin
            frame_cnt++;
            check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                check("frame_value", digit_value, exp_q.pop_front());
        end
        if (seg_error)
            segerr_cnt++;
    end

    initial begin
        reset   = 1'b1;
        led_enb = 8'hFF;
        seg     = 7'h7F;
        repeat (3) @(negedge clk);
        check("reset_outputs", {digit_value, digit_valid, frame_valid, seg_error, enb_error, stale}, 32'h0);
        reset = 1'b0;
        idle(2);

        // Full scan 1,2,3,4 for 6 cycles each.
        exp_q.push_back(16'h4321);
        hold_digit(0, 1, 6);
        hold_digit(1, 2, 6);
        hold_digit(2, 3, 6);
        hold_digit(3, 4, 4);
        @(negedge clk);
        check("frame_pulse_timing", frame_valid, 1'b1);
        hold_digit(3, 4, 2);
        idle(1);
        check("scan_value", digit_value, 16'h4321);
        check("scan_valid", digit_valid, 4'hF);
        check("scan_frame_count", frame_cnt, 1);

        // Three cycles then a seg change: no capture.
        hold_digit(2, 5, 3);
        hold_digit(2, 6, 3);
        idle(1);
        check("short_dwell_value", digit_value, 16'h4321);
        check("short_dwell_valid", digit_valid, 4'hF);

        // Illegal enables.
        drive(8'hFC, 7'h7F, 1);
        idle(1);
        check("enb_err_fc", enb_error, 1'b1);
        idle(1);
        check("enb_err_fc_clear", enb_error, 1'b0);
        drive(8'hEF, ~glyph[9], 1);
        idle(1);
        check("enb_err_ef", enb_error, 1'b1);
        idle(1);
        check("enb_err_ef_clear", enb_error, 1'b0);
        check("enb_err_value", digit_value, 16'h4321);
        check("enb_err_valid", digit_valid, 4'hF);
        // Illegal sample splits a dwell into 2 + 3: no capture.
        hold_digit(0, 9, 2);
        drive(8'hFC, ~glyph[9], 1);
        hold_digit(0, 9, 3);
        idle(1);
        check("enb_err_restart", digit_value, 16'h4321);

        // Blank glyph on digit 1 held long: one seg_error only.
        segerr_base = segerr_cnt;
        hold_raw(1, 7'h7F, 8);
        idle(1);
        check("seg_err_count", segerr_cnt - segerr_base, 1);
        check("seg_err_valid", digit_valid, 4'b1101);
        check("seg_err_value", digit_value, 16'h4321);

        // Recapture digit 1 does not advance the frame; then complete it.
        hold_digit(1, 10, 5);
        idle(1);
        check("recap_value", digit_value, 16'h43A1);
        check("recap_valid", digit_valid, 4'hF);
        check("recap_no_frame", frame_cnt, 1);
        exp_q.push_back(16'hEBAF);
        hold_digit(0, 15, 5);
        hold_digit(2, 11, 5);
        hold_digit(3, 14, 5);
        idle(1);
        check("frame2_count", frame_cnt, 2);

        // Every glyph on digit 2 with exactly SETTLE cycles.
        segerr_base = segerr_cnt;
        for (int g = 0; g < 16; g++) begin
            hold_digit(2, g, 4);
            idle(1);
            check($sformatf("glyph_%0d", g), digit_value[11:8], g[3:0]);
        end
        check("glyph_no_seg_err", segerr_cnt - segerr_base, 0);
        check("glyph_value", digit_value, 16'hEFAF);

        // Timeout.
        idle(60);
        check("not_stale_yet", stale, 1'b0);
        idle(50);
        check("stale_set", stale, 1'b1);
        check("stale_valid", digit_valid, 4'h0);
        hold_digit(3, 7, 4);
        idle(1);
        check("stale_clear", stale, 1'b0);
        check("stale_recap_valid", digit_valid, 4'h8);
        check("stale_recap_value", digit_value, 16'h7FAF);

        // Reset mid-frame and mid-dwell.
        hold_digit(0, 1, 5);
        hold_digit(1, 2, 5);
        hold_digit(2, 3, 2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_outputs", {digit_value, digit_valid, frame_valid, seg_error, enb_error, stale}, 32'h0);
        reset = 1'b0;
        hold_digit(2, 3, 2);
        idle(1);
        check("post_reset_no_capture", digit_valid, 4'h0);
        hold_digit(2, 3, 4);
        idle(1);
        check("post_reset_capture_valid", digit_valid, 4'b0100);
        check("post_reset_capture_value", digit_value, 16'h0300);
        exp_q.push_back(16'hD398);
        hold_digit(0, 8, 5);
        hold_digit(1, 9, 5);
        idle(1);
        check("post_reset_partial", frame_cnt, 2);
        hold_digit(3, 13, 5);
        idle(2);
        check("final_frame_count", frame_cnt, 3);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
